// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
// Shares the CPU's single memory port between instruction fetch (requester 0)
// and data access (requester 1). Round-robin arbitration, one transaction at a
// time, with a per-transaction watchdog that aborts unacknowledged requests.
//
// Ports:
//   clk, rst                  clock, async active-high reset
//   req0, addr0               fetch request / address
//   req1, addr1, we1, wdata1  data request / address / write enable / data
//   mem_req, mem_addr,
//   mem_we, mem_wdata         latched transaction presented to memory
//   mem_rdata, mem_ack        memory read data and single-cycle completion
//   gnt0, gnt1                requester currently owns the port
//   sel                       select for the external address mux2x1
//   done0, done1, rdata, err  one-cycle completion pulse, read data, abort flag
module mem_port_arbiter #(
    parameter int n       = 32,
    parameter int TIMEOUT = 15
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         req0,
    input  logic [n-1:0] addr0,
    input  logic         req1,
    input  logic [n-1:0] addr1,
    input  logic         we1,
    input  logic [n-1:0] wdata1,
    output logic         mem_req,
    output logic [n-1:0] mem_addr,
    output logic         mem_we,
    output logic [n-1:0] mem_wdata,
    input  logic [n-1:0] mem_rdata,
    input  logic         mem_ack,
    output logic         gnt0,
    output logic         gnt1,
    output logic         sel,
    output logic         done0,
    output logic         done1,
    output logic [n-1:0] rdata,
    output logic         err
);

    typedef enum logic [1:0] {IDLE, BUSY0, BUSY1} state_t;

    state_t     state, state_nxt;
    logic       last;      // index of the most recently granted requester
    logic [7:0] cnt;       // BUSY cycles without ack in the current transaction
    logic       grant;
    logic       win;
    logic       timeout;

    // Ownership is a direct decode of the state register, so these are
    // glitch-free registered outputs.
    assign gnt0    = (state == BUSY0);
    assign gnt1    = (state == BUSY1);
    assign mem_req = (state != IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        grant     = 1'b0;
        win       = 1'b0;
        timeout   = (cnt == 8'(TIMEOUT - 1));
        case (state)
            IDLE: begin
                if (req0 && req1) begin
                    grant = 1'b1;
                    win   = ~last;          // tie goes to the one not served last
                end else if (req0) begin
                    grant = 1'b1;
                    win   = 1'b0;
                end else if (req1) begin
                    grant = 1'b1;
                    win   = 1'b1;
                end
                if (grant) state_nxt = win ? BUSY1 : BUSY0;
            end
            BUSY0, BUSY1: begin
                if (mem_ack || timeout) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last      <= 1'b1;
            cnt       <= '0;
            sel       <= 1'b0;
            mem_addr  <= '0;
            mem_we    <= 1'b0;
            mem_wdata <= '0;
            rdata     <= '0;
            done0     <= 1'b0;
            done1     <= 1'b0;
            err       <= 1'b0;
        end else begin
            done0 <= 1'b0;
            done1 <= 1'b0;
            err   <= 1'b0;

            // Winner's fields are captured once and held through IDLE, so the
            // requester may change its inputs while the transaction runs.
            if (grant) begin
                mem_addr  <= win ? addr1 : addr0;
                mem_we    <= win & we1;
                mem_wdata <= win ? wdata1 : '0;
                sel       <= win;
                last      <= win;
                cnt       <= '0;
            end

            if (state != IDLE) begin
                // Ack is checked first so it wins over a same-cycle timeout.
                if (mem_ack) begin
                    rdata <= mem_rdata;
                    done0 <= (state == BUSY0);
                    done1 <= (state == BUSY1);
                end else if (timeout) begin
                    done0 <= (state == BUSY0);
                    done1 <= (state == BUSY1);
                    err   <= 1'b1;
                end else begin
                    cnt <= cnt + 8'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed + randomized bench for mem_port_arbiter (TIMEOUT = 4). A
// transaction-level model predicts the round-robin winner, the completion
// cycle (ack position vs. watchdog limit), err and the returned data.
module tb_mem_port_arbiter;

    localparam int N  = 32;
    localparam int TO = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic         req0, req1, we1, mem_ack;
    logic [N-1:0] addr0, addr1, wdata1, mem_rdata;
    logic         mem_req, mem_we, gnt0, gnt1, sel, done0, done1, err;
    logic [N-1:0] mem_addr, mem_wdata, rdata;

    int checks = 0;
    int errors = 0;

    // reference model state
    int           m_last;
    logic [N-1:0] m_rdata;

    mem_port_arbiter #(.n(N), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .req0(req0), .addr0(addr0),
        .req1(req1), .addr1(addr1), .we1(we1), .wdata1(wdata1),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack),
        .gnt0(gnt0), .gnt1(gnt1), .sel(sel),
        .done0(done0), .done1(done1), .rdata(rdata), .err(err)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "bench did not finish");
    end

    task automatic chk(input string tag, input logic [N-1:0] obs, input logic [N-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Round-robin rule: a lone requester wins; on a tie, the one not served last.
    function automatic int pick(input logic r0, input logic r1);
        if (r0 && r1) return (m_last == 0) ? 1 : 0;
        return r0 ? 0 : 1;
    endfunction

    task automatic check_quiet(input string tag);
        chk({tag, "_mem_req"}, N'(mem_req), '0);
        chk({tag, "_done"},    N'({done0, done1}), '0);
        chk({tag, "_gnt"},     N'({gnt0, gnt1}), '0);
    endtask

    // Requests are already driven; winner w is granted at the next edge.
    // ack_at: BUSY cycle (1-based) on which memory acks; 0 or > TO = never.
    task automatic run_txn(input int w, input int ack_at, input logic [N-1:0] rd,
                           input bit drop);
        logic [N-1:0] e_addr, e_wd;
        logic         e_we, e_err;
        int           fin;
        e_addr = w ? addr1 : addr0;
        e_we   = w ? we1 : 1'b0;
        e_wd   = w ? wdata1 : '0;
        e_err  = !(ack_at >= 1 && ack_at <= TO);
        fin    = e_err ? TO : ack_at;
        m_last = w;
        tick();
        // the latched fields must not follow the inputs after the grant
        addr0 = '0; addr1 = '0; we1 = 1'b0; wdata1 = '0;
        for (int k = 1; k <= fin; k++) begin
            chk("busy_mem_req", N'(mem_req), 1);
            chk("busy_gnt",     N'({gnt1, gnt0}), (w != 0) ? 2 : 1);
            chk("busy_sel",     N'(sel), N'(w));
            chk("busy_addr",    mem_addr, e_addr);
            chk("busy_we",      N'(mem_we), N'(e_we));
            chk("busy_wdata",   mem_wdata, e_wd);
            chk("busy_nodone",  N'({done0, done1}), '0);
            if (k == ack_at) begin
                mem_ack = 1'b1; mem_rdata = rd;
            end else begin
                mem_ack = 1'b0; mem_rdata = $urandom;
            end
            if (drop && k == 1) begin
                if (w != 0) req1 = 1'b0; else req0 = 1'b0;
            end
            tick();
        end
        mem_ack = 1'b0;
        if (!e_err) m_rdata = rd;
        chk("done_pulse", N'({done1, done0}), (w != 0) ? 2 : 1);
        chk("done_err",   N'(err), N'(e_err));
        chk("done_rdata", rdata, m_rdata);
        chk("done_mreq",  N'(mem_req), '0);
        chk("done_gnt",   N'({gnt0, gnt1}), '0);
        chk("done_hold_addr", mem_addr, e_addr);
        chk("done_hold_sel",  N'(sel), N'(w));
    endtask

    initial begin
        rst = 1'b1; req0 = 0; req1 = 0; we1 = 0; mem_ack = 0;
        addr0 = '0; addr1 = '0; wdata1 = '0; mem_rdata = '0;
        m_last = 1; m_rdata = '0;
        repeat (2) @(posedge clk);
        #1;
        // reset defaults
        check_quiet("rst");
        chk("rst_sel",   N'(sel), '0);
        chk("rst_addr",  mem_addr, '0);
        chk("rst_we",    N'(mem_we), '0);
        chk("rst_wdata", mem_wdata, '0);
        chk("rst_rdata", rdata, '0);
        chk("rst_err",   N'(err), '0);
        rst = 1'b0;
        tick();

        // reset mid-transaction in BUSY1
        req1 = 1'b1; addr1 = 32'h0000_0ABC; we1 = 1'b1; wdata1 = 32'h1234_5678;
        tick();
        chk("mid_gnt1", N'(gnt1), 1);
        tick();
        #2 rst = 1'b1;
        #1;
        check_quiet("midrst");
        chk("midrst_sel",   N'(sel), '0);
        chk("midrst_addr",  mem_addr, '0);
        chk("midrst_we",    N'(mem_we), '0);
        req1 = 1'b0; we1 = 1'b0; addr1 = '0; wdata1 = '0;
        mem_ack = 1'b1;
        tick();
        rst = 1'b0; m_last = 1; m_rdata = '0;
        tick();
        mem_ack = 1'b0;
        check_quiet("postrst");
        tick();
        check_quiet("postrst2");

        // contention from reset: 0,1,0,1, each grant one cycle after done
        req0 = 1'b1; req1 = 1'b1;
        for (int i = 0; i < 4; i++) begin
            addr0 = $urandom; addr1 = $urandom; wdata1 = $urandom; we1 = 1'($urandom);
            chk("cont_order", N'(pick(1'b1, 1'b1)), N'(i % 2));
            run_txn(pick(1'b1, 1'b1), 1 + (i % 2), $urandom, 1'b0);
            req0 = 1'b1; req1 = 1'b1;
        end
        req0 = 1'b0; req1 = 1'b0;
        tick();
        check_quiet("cont_idle");

        // single fetch, ack on 2nd BUSY cycle
        req0 = 1'b1; addr0 = 32'h100;
        run_txn(pick(1'b1, 1'b0), 2, 32'hDEAD_BEEF, 1'b1);
        tick();
        check_quiet("fetch_idle");

        // data write, inputs zeroed during BUSY1
        req1 = 1'b1; we1 = 1'b1; addr1 = 32'h20; wdata1 = 32'h55;
        run_txn(pick(1'b0, 1'b1), 3, $urandom, 1'b1);
        tick();

        // watchdog: no ack -> abort after TO cycles, rdata unchanged
        req1 = 1'b1; addr1 = 32'h44;
        run_txn(pick(1'b0, 1'b1), 0, $urandom, 1'b1);
        tick();
        // ack on the last allowed cycle wins over the timeout
        req1 = 1'b1; addr1 = 32'h48;
        run_txn(pick(1'b0, 1'b1), TO, 32'hCAFE_F00D, 1'b1);
        tick();

        // withdrawn request still completes; spurious ack in IDLE is ignored
        req0 = 1'b1; addr0 = 32'h200;
        run_txn(pick(1'b1, 1'b0), 3, 32'h0BAD_F00D, 1'b1);
        tick();
        mem_ack = 1'b1; mem_rdata = 32'hFFFF_FFFF;
        tick();
        mem_ack = 1'b0;
        check_quiet("spurious");
        chk("spurious_rdata", rdata, m_rdata);

        // randomized transactions
        for (int i = 0; i < 40; i++) begin
            logic r0, r1;
            r0 = 1'($urandom); r1 = 1'($urandom);
            if (!r0 && !r1) r0 = 1'b1;
            req0 = r0; req1 = r1;
            addr0 = $urandom; addr1 = $urandom; wdata1 = $urandom; we1 = 1'($urandom);
            run_txn(pick(r0, r1), $urandom_range(0, TO + 2), $urandom, 1'b1);
            req0 = 1'b0; req1 = 1'b0;
            tick();
            check_quiet("rand_idle");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
